// File: rtl/pe_ctrl_sequencer.sv
// Issues a stored program of PE control words to one PE, retiring one word per output_ready.
// Optional multi-pass looping is compiled in when PE_SEQ_LOOP_EN is defined.
module pe_ctrl_sequencer #(
    parameter int CTRL_WIDTH = 13,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [CTRL_WIDTH-1:0] cfg_data,
    input  logic [AW:0]           prog_len,
    input  logic [7:0]            loop_count,
    input  logic                  start,
    input  logic                  output_ready,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  en,
    output logic                  input_ready,
    output logic [AW-1:0]         pc,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [CTRL_WIDTH-1:0] mem [DEPTH];

    state_t                state_reg, state_next;
    logic [AW-1:0]         pc_reg, pc_next;
    logic [AW-1:0]         len_reg, len_next;
    logic                  err_reg, err_next;
    logic [CTRL_WIDTH-1:0] ctrl_reg;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  ctrl_clr;
    logic                  mem_we;
    logic                  addr_ok;
    logic                  len_ok;
    logic                  more_passes;

    // Widened compares keep the range checks meaningful for any DEPTH.
    assign addr_ok = ({1'b0, cfg_addr} < DEPTH_L);
    assign len_ok  = (prog_len < DEPTH_L);

`ifdef PE_SEQ_LOOP_EN
    logic [7:0] pass_reg, pass_next;
    logic [7:0] lc_reg, lc_next;

    assign more_passes = (pass_reg < lc_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pass_reg <= '0;
            lc_reg   <= '0;
        end else begin
            pass_reg <= pass_next;
            lc_reg   <= lc_next;
        end
    end
`else
    logic unused_loop_count;
    assign unused_loop_count = ^loop_count;
    assign more_passes       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        len_next   = len_reg;
        err_next   = err_reg;
        rd_en      = 1'b0;
        rd_addr    = pc_reg;
        ctrl_clr   = 1'b0;
        mem_we     = 1'b0;
`ifdef PE_SEQ_LOOP_EN
        pass_next  = pass_reg;
        lc_next    = lc_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (cfg_we) begin
                    if (addr_ok) mem_we = 1'b1;
                    else         err_next = 1'b1;
                end else if (start) begin
                    if (len_ok) begin
                        state_next = ISSUE;
                        len_next   = prog_len[AW-1:0];
                        err_next   = 1'b0;
                        pc_next    = '0;
                        rd_en      = 1'b1;
                        rd_addr    = '0;
`ifdef PE_SEQ_LOOP_EN
                        pass_next  = '0;
                        lc_next    = loop_count;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cfg_we) err_next = 1'b1;
                if (output_ready) begin
                    if (pc_reg < len_reg) begin
                        pc_next = pc_reg + AW'(1);
                        rd_en   = 1'b1;
                        rd_addr = pc_reg + AW'(1);
                    end else if (more_passes) begin
                        pc_next   = '0;
                        rd_en     = 1'b1;
                        rd_addr   = '0;
`ifdef PE_SEQ_LOOP_EN
                        pass_next = pass_reg + 8'd1;
`endif
                    end else begin
                        state_next = DONE;
                        ctrl_clr   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (cfg_we) err_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            len_reg   <= len_next;
            err_reg   <= err_next;
        end
    end

    // Registered memory read doubles as the ctrl output register.
    always_ff @(posedge clk) begin
        if (!reset)        ctrl_reg <= '0;
        else if (rd_en)    ctrl_reg <= mem[rd_addr];
        else if (ctrl_clr) ctrl_reg <= '0;
    end

    // Context memory is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[cfg_addr] <= cfg_data;
    end

    assign ctrl        = ctrl_reg;
    assign en          = (state_reg == ISSUE);
    assign input_ready = (state_reg == ISSUE);
    assign pc          = pc_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign cfg_err     = err_reg;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed bench for pe_ctrl_sequencer: reset, run, stall, error, mid-run reset and loop cases.
module tb_pe_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [12:0] cfg_data;
    logic [4:0]  prog_len;
    logic [7:0]  loop_count;
    logic        start;
    logic        output_ready;
    logic [12:0] ctrl;
    logic        en;
    logic        input_ready;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign output_ready = en & input_ready & ~stall;

    pe_ctrl_sequencer dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .prog_len(prog_len), .loop_count(loop_count),
        .start(start), .output_ready(output_ready), .ctrl(ctrl), .en(en),
        .input_ready(input_ready), .pc(pc), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [12:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    logic [12:0] exp_seq [$];

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        prog_len = '0; loop_count = '0; start = 1'b0; stall = 1'b0;

        step(); step();
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_ir", 32'(input_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_pc", 32'(pc), 0);
        reset = 1'b1;

        write_word(4'd0, 13'h0A25);
        write_word(4'd1, 13'h1B31);
        write_word(4'd2, 13'h0C07);
        $display("[TB] program loaded");

        // Basic run
        prog_len = 5'd2; start = 1'b1;
        step(); start = 1'b0;
        chk("run_w0", 32'(ctrl), 32'h0A25);
        chk("run_en0", 32'(en), 1);
        chk("run_busy0", 32'(busy), 1);
        step();
        chk("run_w1", 32'(ctrl), 32'h1B31);
        chk("run_pc1", 32'(pc), 1);
        step();
        chk("run_w2", 32'(ctrl), 32'h0C07);
        step();
        chk("run_done", 32'(done), 1);
        chk("run_done_ctrl", 32'(ctrl), 0);
        chk("run_done_en", 32'(en), 0);
        chk("run_done_pc", 32'(pc), 2);
        step();
        chk("run_idle_busy", 32'(busy), 0);
        chk("run_idle_done", 32'(done), 0);
        $display("[TB] basic run complete");

        // Stall at pc=1 for three cycles
        start = 1'b1;
        step(); start = 1'b0;
        chk("stl_w0", 32'(ctrl), 32'h0A25);
        step();
        chk("stl_w1a", 32'(ctrl), 32'h1B31);
        stall = 1'b1;
        step();
        chk("stl_w1b", 32'(ctrl), 32'h1B31);
        chk("stl_en", 32'(en), 1);
        step();
        chk("stl_w1c", 32'(ctrl), 32'h1B31);
        chk("stl_pc", 32'(pc), 1);
        step();
        chk("stl_w1d", 32'(ctrl), 32'h1B31);
        chk("stl_nodone", 32'(done), 0);
        stall = 1'b0;
        step();
        chk("stl_w2", 32'(ctrl), 32'h0C07);
        step();
        chk("stl_done", 32'(done), 1);
        step();
        chk("stl_idle", 32'(busy), 0);
        $display("[TB] stall run complete");

        // cfg_we during ISSUE is dropped and flagged
        start = 1'b1;
        step(); start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 13'h1FFF;
        step(); cfg_we = 1'b0;
        chk("err1_flag", 32'(cfg_err), 1);
        chk("err1_w1", 32'(ctrl), 32'h1B31);
        step(); step(); step();
        chk("err1_idle", 32'(busy), 0);
        chk("err1_sticky", 32'(cfg_err), 1);
        start = 1'b1;
        step(); start = 1'b0;
        chk("err1_clear", 32'(cfg_err), 0);
        chk("err1_mem", 32'(ctrl), 32'h0A25);
        step(); step(); step(); step();
        chk("err1_end", 32'(busy), 0);
        $display("[TB] busy-write error case complete");

        // prog_len out of range is rejected
        prog_len = 5'd16; start = 1'b1;
        step(); start = 1'b0;
        chk("err2_flag", 32'(cfg_err), 1);
        chk("err2_busy", 32'(busy), 0);
        chk("err2_en", 32'(en), 0);
        prog_len = 5'd2;
        $display("[TB] rejected start case complete");

        // start with cfg_we: write wins, start ignored; written word visible next start
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 13'h0123; start = 1'b1;
        step(); cfg_we = 1'b0;
        chk("sw_busy", 32'(busy), 0);
        prog_len = 5'd3;
        step(); start = 1'b0;
        chk("sw_busy2", 32'(busy), 1);
        chk("sw_errclr", 32'(cfg_err), 0);
        step(); step(); step();
        chk("sw_w3", 32'(ctrl), 32'h0123);
        chk("sw_pc3", 32'(pc), 3);
        step(); step();
        chk("sw_end", 32'(busy), 0);
        prog_len = 5'd2;
        $display("[TB] start+write case complete");

        // Reset mid-run
        start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("mr_pc1", 32'(pc), 1);
        reset = 1'b0;
        step();
        chk("mr_ctrl", 32'(ctrl), 0);
        chk("mr_en", 32'(en), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_pc", 32'(pc), 0);
        chk("mr_done", 32'(done), 0);
        reset = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk("mr_restart", 32'(ctrl), 32'h0A25);
        step(); step(); step(); step();
        chk("mr_end", 32'(busy), 0);
        $display("[TB] mid-run reset case complete");

        // Loop case
        exp_seq.push_back(13'h0A25);
        exp_seq.push_back(13'h1B31);
`ifdef PE_SEQ_LOOP_EN
        for (int p = 0; p < 2; p++) begin
            exp_seq.push_back(13'h0A25);
            exp_seq.push_back(13'h1B31);
        end
`endif
        prog_len = 5'd1; loop_count = 8'd2; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i != 0) step();
            chk($sformatf("loop_w%0d", i), 32'(ctrl), 32'(exp_seq[i]));
            chk($sformatf("loop_nd%0d", i), 32'(done), 0);
        end
        step();
        chk("loop_done", 32'(done), 1);
        step();
        chk("loop_done_once", 32'(done), 0);
        chk("loop_idle", 32'(busy), 0);
        $display("[TB] loop case complete (%0d words)", exp_seq.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_ctrl_sequencer.md
# pe_ctrl_sequencer

Issues a stored program of PE control words to one PE of the array, cycle by cycle. It drives `ctrl`, `en` and `input_ready` into the PE and retires each word when the PE returns `output_ready`. It sits between the array configuration bus and a single PE, and replaces static per-PE ctrl tie-offs. It holds a small context memory loaded over a simple write port, runs on `start`, and signals completion with a `done` pulse.

## Interface
- `CTRL_WIDTH`, 13, PE ctrl word width: output(3)_op1(3)_op2(3)_opcode(4).
- `DEPTH`, 16, context memory entries. `AW = $clog2(DEPTH)` is a localparam.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_we`  in  1  context memory write strobe.
- `cfg_addr`  in  AW  write address.
- `cfg_data`  in  CTRL_WIDTH  write data.
- `prog_len`  in  AW+1  index of the last word; latched at accepted start.
- `loop_count`  in  8  extra passes; latched at accepted start; used only with the macro.
- `start`  in  1  run request, level-sampled.
- `output_ready`  in  1  retire handshake from the PE.
- `ctrl`  out  CTRL_WIDTH  registered ctrl word to the PE.
- `en`  out  1  registered PE enable.
- `input_ready`  out  1  registered PE operand-valid.
- `pc`  out  AW  index of the word currently issued.
- `busy`  out  1  high in ISSUE and DONE states.
- `done`  out  1  one-cycle completion pulse.
- `cfg_err`  out  1  sticky configuration error flag.

## Operation
- Reset state:
  - All outputs 0; state IDLE.
  - Context memory is NOT cleared. Its contents are undefined after power-up.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - `cfg_we=1` with `cfg_addr<DEPTH` writes the memory.
  - `cfg_we=1` with `cfg_addr>=DEPTH` is dropped and sets `cfg_err`.
  - `start=1` with `cfg_we=0` and `prog_len<DEPTH` is accepted: latch `prog_len` and `loop_count`, clear `cfg_err`, set `pc=0`, pass counter 0, go to ISSUE.
  - `start=1` with `prog_len>=DEPTH` is rejected: `cfg_err`=1, stay in IDLE.
  - `start` and `cfg_we` in the same cycle: the write is performed and `start` is ignored.
- ISSUE:
  - `ctrl=mem[pc]`, `en=1`, `input_ready=1`.
  - Each cycle `output_ready=1`, word `pc` retires:
    - If `pc<prog_len`: `pc` increments.
    - Else if passes remain: `pc=0` and the pass counter increments.
    - Else: go to DONE.
  - `output_ready=0` stalls: `ctrl`, `en` and `pc` hold.
- DONE:
  - `en=0`, `input_ready=0`, `ctrl=0`, `done=1` for exactly one cycle, then IDLE.
  - `pc` holds the last index until the next start.
- Busy-state rules:
  - `cfg_we` in ISSUE or DONE is ignored and sets `cfg_err`.
  - `start` in ISSUE or DONE is ignored.
- `cfg_err` holds until the next accepted start or reset.

## Timing
- `start` sampled high at edge k: `ctrl=mem[0]`, `en=1`, `busy=1` from cycle k+1.
- Throughput is 1 word/cycle while `output_ready` stays high.
- Word retired at edge j: the next word appears at cycle j+1.
- Last word retired at edge j: `done=1` in cycle j+1, `busy=0` from cycle j+2.
- Minimum program run with `prog_len=0` and no stall is 3 cycles start-to-idle, including the DONE cycle.
- Memory write at edge k is visible to a start accepted at edge k+1.
- `reset=0` at any edge (mid-run included): all outputs are 0 in the following cycle and the state is IDLE; memory keeps its contents.

## Configuration
- Macro: `PE_SEQ_LOOP_EN`.
- Defined:
  - The program runs `loop_count+1` passes; an 8-bit pass counter is compiled in.
  - `done` pulses once, after the final pass only.
- Undefined:
  - Exactly one pass.
  - The `loop_count` port remains but is ignored; no pass counter exists.

## Test plan
- Reset: hold `reset=0` for 2 cycles → `ctrl=0`, `en=0`, `input_ready=0`, `busy=0`, `done=0`, `cfg_err=0`, `pc=0`.
- Basic run: load 0x0A25, 0x1B31, 0x0C07 at addresses 0-2, `prog_len=2`, `output_ready=en&input_ready`, start at edge k → `ctrl` shows the three words in cycles k+1..k+3; `done` in k+4; `busy=0` at k+5.
- Stall: same program, `output_ready=0` for 3 cycles while `pc=1` → 0x1B31 held for 4 cycles, `en` stays 1, `done` delayed exactly 3 cycles.
- Errors, part 1: `cfg_we` during ISSUE → memory unchanged, `cfg_err=1`; the next accepted start clears it.
- Errors, part 2: `prog_len=16` with `DEPTH=16` → start rejected, `cfg_err=1`, `busy=0`.
- Reset mid-run at `pc=1` → next cycle all outputs 0; a restart issues 0x0A25 first, proving the memory was retained.
- Loop (macro defined): `loop_count=2`, `prog_len=1`, words 0x0A25/0x1B31 → 6 words alternating, a single `done`. With the macro undefined, the same stimulus gives 2 words then `done`.
